// File: rtl/nv_nvdla_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_fifo_pkg
//  Description : Shared sizing helpers and parameter legality checks for the
//                NVDLA parameterised FIFO family.
//  Revision    : 1.0 - initial release
// ============================================================================
package nv_nvdla_fifo_pkg;

   localparam int FIFO_MIN_WIDTH = 1;
   localparam int FIFO_MAX_WIDTH = 512;
   localparam int FIFO_MIN_DEPTH = 2;
   localparam int FIFO_MAX_DEPTH = 1024;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int fifo_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a RAM pointer; pointers wrap naturally because depth is 2^n.
   function automatic int fifo_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic bit fifo_is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // True when the WIDTH/DEPTH/AFULL_TH combination is supported.
   function automatic bit fifo_params_ok(input int width, input int depth, input int afull_th);
      bit ok;
      ok = 1'b1;
      if (width < FIFO_MIN_WIDTH || width > FIFO_MAX_WIDTH) ok = 1'b0;
      if (depth < FIFO_MIN_DEPTH || depth > FIFO_MAX_DEPTH) ok = 1'b0;
      if (!fifo_is_pow2(depth)) ok = 1'b0;
      if (afull_th < 1 || afull_th > depth) ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nv_ram_rwsp_param.sv
`default_nettype none
// ============================================================================
//  Module      : nv_ram_rwsp_param
//  Description : DEPTH x WIDTH storage, one synchronous write port and one
//                synchronous read port. A read that collides with a write to
//                the same address returns the incoming write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module nv_ram_rwsp_param
   import nv_nvdla_fifo_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 32,
   localparam int AW    = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic [AW-1:0]    wa,
   input  logic             we,
   input  logic [WIDTH-1:0] di,
   input  logic [AW-1:0]    ra,
   input  logic             re,
   output logic [WIDTH-1:0] dout,
   input  logic             ore,
   input  logic [31:0]      pwrbus_ram_pd
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] dout_d;
   logic [WIDTH-1:0] dout_q;

   // Power control has no behavioural effect in this model of the macro.
   logic unused_pwrbus;
   assign unused_pwrbus = ^pwrbus_ram_pd;

   // Array write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wa] <= di;
      end
   end

   // Read word selection with write-through on address collision, and read
   // register next value (re gates the array access, ore the register).
   always_comb begin
      rd_word = mem_q[ra];
      if (we && (wa == ra)) begin
         rd_word = di;
      end
      dout_d = dout_q;
      if (re && ore) begin
         dout_d = rd_word;
      end
   end

   // Read data register.
   always_ff @(posedge clk) begin
      dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/nv_nvdla_cdma_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_cdma_param_fifo
//  Description : Valid/ready FIFO over a synchronous RAM. Read path is
//                RAM read register -> registered output stage, giving a
//                two-cycle first-word latency and full streaming rate.
//                Supports a runtime capacity cap and a synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_cdma_param_fifo
   import nv_nvdla_fifo_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int AFULL_TH = DEPTH - 4,
   localparam int CW       = fifo_cw(DEPTH),
   localparam int AW       = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             wr_req,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_req,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   input  logic             flush,
   input  logic [CW-1:0]    wr_limit,
   output logic [CW-1:0]    count,
   output logic             afull,
   input  logic [31:0]      pwrbus_ram_pd
);

   if (!fifo_params_ok(WIDTH, DEPTH, AFULL_TH)) begin : g_param_check
      $error("nv_nvdla_cdma_param_fifo: unsupported WIDTH/DEPTH/AFULL_TH");
   end

   // Registered state
   logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]    count_q,    count_d;
   logic             wr_ready_q, wr_ready_d;
   logic             afull_q,    afull_d;
   logic             s1_vld_q,   s1_vld_d;   // RAM read register holds a live word
   logic             rd_req_q,   rd_req_d;   // output stage holds a live word
   logic [WIDTH-1:0] rd_data_q,  rd_data_d;

   // Combinational control
   logic [CW-1:0]    eff_limit;
   logic [CW-1:0]    stage_cnt;
   logic             ram_has_word;
   logic             push;
   logic             pop;
   logic             out_load;
   logic             fetch;
   logic [WIDTH-1:0] ram_dout;

   // Resolve the runtime cap: zero or anything above DEPTH means full depth.
   always_comb begin
      eff_limit = wr_limit;
      if ((wr_limit == '0) || (wr_limit > CW'(DEPTH))) begin
         eff_limit = CW'(DEPTH);
      end
   end

   // Handshakes and read-pipeline movement. Words still sitting in the RAM
   // are the accepted count minus those already in the two read stages.
   always_comb begin
      push         = wr_req && wr_ready_q && !flush;
      pop          = rd_req_q && rd_ready && !flush;
      stage_cnt    = CW'(s1_vld_q) + CW'(rd_req_q);
      ram_has_word = (count_q > stage_cnt);
      out_load     = s1_vld_q && (!rd_req_q || pop);
      // A word written this cycle may be fetched at once via write-through.
      fetch        = (ram_has_word || push) && (!s1_vld_q || out_load) && !flush;
   end

   // Next-state for pointers, stages, count and the registered flags.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      s1_vld_d  = fetch || (s1_vld_q && !out_load);
      rd_req_d  = out_load || (rd_req_q && !pop);
      rd_data_d = out_load ? ram_dout : rd_data_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (fetch) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         s1_vld_d  = 1'b0;
         rd_req_d  = 1'b0;
         rd_data_d = '0;
      end

      // Capacity can drop below count at runtime; ready then stays low until
      // pops bring count under the new cap, so nothing is overwritten.
      wr_ready_d = (count_d < eff_limit);
      afull_d    = (count_d >= CW'(AFULL_TH));
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_ready_q <= 1'b1;
         afull_q    <= 1'b0;
         s1_vld_q   <= 1'b0;
         rd_req_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wr_ready_q <= wr_ready_d;
         afull_q    <= afull_d;
         s1_vld_q   <= s1_vld_d;
         rd_req_q   <= rd_req_d;
         rd_data_q  <= rd_data_d;
      end
   end

   nv_ram_rwsp_param #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk           (clk),
      .wa            (wr_ptr_q),
      .we            (push),
      .di            (wr_data),
      .ra            (rd_ptr_q),
      .re            (fetch),
      .dout          (ram_dout),
      .ore           (fetch),
      .pwrbus_ram_pd (pwrbus_ram_pd)
   );

   assign wr_ready = wr_ready_q;
   assign rd_req   = rd_req_q;
   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign afull    = afull_q;

endmodule
`default_nettype wire

// File: doc/nv_nvdla_cdma_param_fifo.md
NV_NVDLA_CDMA_PARAM_FIFO -- requirements
Module: nv_nvdla_cdma_param_fifo

Interface
REQ-001 Parameter WIDTH, 32, data width in bits (1..512).
REQ-002 Parameter DEPTH, 32, storage words; SHALL be a power of two, 2..1024.
REQ-003 Parameter AFULL_TH, DEPTH-4, almost-full threshold in words (1..DEPTH).
REQ-004 Port clk  input  1  sole clock; all flops on its rising edge.
REQ-005 Port reset_  input  1  reset, asynchronous assertion, active-low.
REQ-006 Port wr_req  input  1  write valid.
REQ-007 Port wr_ready  output  1  write ready; the word transfers when wr_req && wr_ready.
REQ-008 Port wr_data  input  WIDTH  write data.
REQ-009 Port rd_req  output  1  read valid.
REQ-010 Port rd_ready  input  1  read ready; the word transfers when rd_req && rd_ready.
REQ-011 Port rd_data  output  WIDTH  read data.
REQ-012 Port flush  input  1  synchronous discard of all contents.
REQ-013 Port wr_limit  input  CW  runtime capacity cap; 0 or a value > DEPTH means DEPTH. CW = clog2(DEPTH+1).
REQ-014 Port count  output  CW  words accepted and not yet popped, including the word in the output stage.
REQ-015 Port afull  output  1  count >= AFULL_TH.
REQ-016 Port pwrbus_ram_pd  input  32  RAM power control; passed through to the storage.

Function
REQ-017 Storage SHALL be a DEPTH x WIDTH RAM with one synchronous write port and one synchronous read port, feeding a registered output stage.
REQ-018 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-019 On an empty FIFO, a write accepted at edge E SHALL assert rd_req after edge E+1, so first-word latency is 2 cycles.
REQ-020 Streaming throughput SHALL be 1 word per cycle in both directions, with no bubbles when rd_ready is held high.
REQ-021 While rd_req && !rd_ready, rd_req and rd_data SHALL hold stable.
REQ-022 count SHALL be registered: count_next = count + push - pop, and it SHALL never wrap.
REQ-023 wr_ready SHALL be registered and equal (count_next < eff_limit), where eff_limit is the capacity resolved per REQ-013.
REQ-024 A write and a pop in the same cycle SHALL leave count unchanged.
REQ-025 A pop at full SHALL raise wr_ready on the next cycle.
REQ-026 If wr_limit is lowered below count, no data SHALL be lost: wr_ready stays 0 until count < eff_limit.
REQ-027 afull SHALL be registered from count_next.
REQ-028 flush SHALL take priority over everything else; after the edge it is sampled:
- count=0, rd_req=0, pointers=0, afull=0, wr_ready=1;
- a write or pop presented in the flush cycle is discarded.
REQ-029 Order SHALL be strictly FIFO; no word may be duplicated or dropped except by flush.
REQ-030 A pop while empty or a push while full SHALL be impossible by construction, because rd_req and wr_ready gate them.

Reset
REQ-031 While reset_=0 and after its release, outputs SHALL be wr_ready=1, rd_req=0, rd_data=0, count=0, afull=0.
REQ-032 Pointers and the output stage SHALL reset to 0; RAM contents are not reset.
REQ-033 Reset asserted mid-operation SHALL discard all contents immediately and asynchronously.
REQ-034 Reset deassertion SHALL be synchronised externally; the block adds no reset synchroniser.

Structure
REQ-035 The CW/pointer-width helper function and the parameter legality checks SHALL live in shared package nv_nvdla_fifo_pkg.
REQ-036 Storage SHALL be one sub-module, nv_ram_rwsp_param (WIDTH, DEPTH), with ports wa/we/di/ra/re/dout/ore/pwrbus_ram_pd.
REQ-037 Control, count and output-stage logic SHALL stay in the top module.

Verification (DEPTH=32, WIDTH=32, AFULL_TH=28, wr_limit=0 unless stated)
REQ-038 Write 1 word 0xA5A5_0001 into an empty FIFO at edge E, rd_ready=1 -> rd_req=1 after E+1 with rd_data=0xA5A5_0001; count returns to 0.
REQ-039 Write 32 words 0..31 with rd_ready=0 -> wr_ready=0 after the 32nd accept, count=32, afull=1; one pop -> wr_ready=1 the next cycle; output order is 0..31.
REQ-040 With full=32, hold wr_req=1 and rd_ready=1 for 100 cycles -> one push and one pop every cycle, count stays at 31/32, no data mismatch.
REQ-041 Set wr_limit=8 with count=12 -> wr_ready stays 0 until 5 pops bring count to 7; then 1 write is accepted.
REQ-042 Assert flush with count=20 and simultaneous wr_req/rd_ready -> next cycle count=0, rd_req=0, wr_ready=1; the next written word 0x55 is the first word read.
REQ-043 Assert reset_ low mid-stream for 3 cycles -> all outputs at their reset values; traffic after release is correct and contains no stale words.
